mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage, upstream of write-back.
- Consumes the registered execute results, runs loads/stores on a req/gnt/rvalid data-memory port, formats load data, and registers the result into the MEM/WB pipeline register.
- Raises a stall that freezes every upstream stage while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_load_align.sv | 26 ++
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: access size codes,
// handshake FSM states, write-back source selects and a size decoder.
// No ports; imported by mem_stage and mem_stage_load_align.
package mem_stage_pkg;

  localparam int DW = 32;

  // funct3 size codes carried on EX_mem_op_i
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_G = 2'd1,
    WAIT_R = 2'd2
  } state_e;

  // write-back source selects, passed through to MEM/WB untouched
  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_PC4 = 2'b10
  } sel_to_reg_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsupported codes (011, 110, 111) fall into the word case.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      MEM_B, MEM_BU: return SZ_B;
      MEM_H, MEM_HU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data formatter: shifts the read word down to the addressed lane and extends it.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: rdata (read word), off (byte offset), mem_op (size code), data (formatted result).
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  mem_op,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (mem_op)
      MEM_B:   data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_BU:  data = {24'd0, shifted[7:0]};
      MEM_HU:  data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on a req/gnt/rvalid port and fills the MEM/WB register.
// Latency: ALU ops 1 cycle; loads 1 cycle plus grant and read-data wait cycles.
// Backpressure: stall_o freezes all upstream stages while an access is pending; MEM/WB gets bubbles.
// Ports: EX_* execute results in; dmem_* data-memory port; stall_o; MEM_fwd_data_o (comb);
//        MEM_* registered MEM/WB outputs including a one-cycle misalignment pulse.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] EX_alu_result_i,
  input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
  input  logic [4:0]            EX_rd_add_i,
  input  logic                  EX_regwrite_i,
  input  logic [1:0]            EX_sel_to_reg_i,
  input  logic                  EX_RD_mem_i,
  input  logic                  EX_WR_mem_i,
  input  logic [2:0]            EX_mem_op_i,
  input  logic [DATA_WIDTH-1:0] EX_pc_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] MEM_fwd_data_o,
  output logic [4:0]            MEM_rd_add_o,
  output logic                  MEM_regwrite_o,
  output logic [1:0]            MEM_sel_to_reg_o,
  output logic [DATA_WIDTH-1:0] MEM_alu_result_o,
  output logic [DATA_WIDTH-1:0] MEM_load_data_o,
  output logic [DATA_WIDTH-1:0] MEM_pc_o,
  output logic                  MEM_misalign_o
);

  state_e      state_q, state_d;
  size_e       size;
  logic [1:0]  off;
  logic        is_load, is_store, is_mem, misalign, access, load_done;
  logic [31:0] load_data;

  assign off      = EX_alu_result_i[1:0];
  assign size     = op_size(EX_mem_op_i);
  // a load flagged together with a store wins
  assign is_load  = EX_RD_mem_i;
  assign is_store = EX_WR_mem_i & ~EX_RD_mem_i;
  assign is_mem   = is_load | is_store;
  assign misalign = is_mem & (((size == SZ_H) & off[0]) | ((size == SZ_W) & (off != 2'b00)));
  assign access   = is_mem & ~misalign;
  assign load_done = (state_q == WAIT_R) & dmem_rvalid_i;

  assign MEM_fwd_data_o = EX_alu_result_i;

  // Address/data are driven straight from the (frozen) EX inputs, so they stay
  // stable in WAIT_G without extra holding registers.
  assign dmem_addr_o = {EX_alu_result_i[DATA_WIDTH-1:2], 2'b00};
  assign dmem_we_o   = is_store;

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = EX_rs2_data_i;
    if (is_store) begin
      case (size)
        SZ_B: begin
          dmem_be_o    = 4'b0001 << off;
          dmem_wdata_o = {4{EX_rs2_data_i[7:0]}};
        end
        SZ_H: begin
          dmem_be_o    = 4'b0011 << off;
          dmem_wdata_o = {2{EX_rs2_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (!dmem_gnt_i)   state_d = WAIT_G;
          else if (is_load)  state_d = WAIT_R;
        end
      end
      WAIT_G: if (dmem_gnt_i)    state_d = is_load ? WAIT_R : IDLE;
      WAIT_R: if (dmem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Stall drops in the cycle the access completes (store grant
  // or read data), so the instruction retires into MEM/WB on that edge.
  always_comb begin
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req_o = access;
        stall_o    = access & ~(dmem_gnt_i & is_store);
      end
      WAIT_G: begin
        dmem_req_o = 1'b1;
        stall_o    = ~(dmem_gnt_i & is_store);
      end
      WAIT_R:  stall_o = ~dmem_rvalid_i;
      default: ;
    endcase
    if (rst) begin
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
    end
  end

  mem_stage_load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .off    (off),
    .mem_op (EX_mem_op_i),
    .data   (load_data)
  );

  // MEM/WB register. A bubble is all-zero, the same as the reset value.
  always_ff @(posedge clk) begin
    if (rst || stall_o) begin
      MEM_rd_add_o     <= '0;
      MEM_regwrite_o   <= 1'b0;
      MEM_sel_to_reg_o <= '0;
      MEM_alu_result_o <= '0;
      MEM_load_data_o  <= '0;
      MEM_pc_o         <= '0;
      MEM_misalign_o   <= 1'b0;
    end else begin
      MEM_rd_add_o     <= EX_rd_add_i;
      MEM_regwrite_o   <= EX_regwrite_i & ~misalign;
      MEM_sel_to_reg_o <= EX_sel_to_reg_i;
      MEM_alu_result_o <= EX_alu_result_i;
      MEM_load_data_o  <= load_done ? load_data : '0;
      MEM_pc_o         <= EX_pc_i;
      MEM_misalign_o   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_alu_result_i, EX_rs2_data_i, EX_pc_i;
  logic [4:0]  EX_rd_add_i;
  logic        EX_regwrite_i, EX_RD_mem_i, EX_WR_mem_i;
  logic [1:0]  EX_sel_to_reg_i;
  logic [2:0]  EX_mem_op_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        stall_o;
  logic [31:0] MEM_fwd_data_o, MEM_alu_result_o, MEM_load_data_o, MEM_pc_o;
  logic [4:0]  MEM_rd_add_o;
  logic        MEM_regwrite_o, MEM_misalign_o;
  logic [1:0]  MEM_sel_to_reg_o;

  int checks = 0;
  int errors = 0;
  bit op_bad;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .EX_alu_result_i(EX_alu_result_i), .EX_rs2_data_i(EX_rs2_data_i),
    .EX_rd_add_i(EX_rd_add_i), .EX_regwrite_i(EX_regwrite_i),
    .EX_sel_to_reg_i(EX_sel_to_reg_i), .EX_RD_mem_i(EX_RD_mem_i),
    .EX_WR_mem_i(EX_WR_mem_i), .EX_mem_op_i(EX_mem_op_i), .EX_pc_i(EX_pc_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .MEM_fwd_data_o(MEM_fwd_data_o),
    .MEM_rd_add_o(MEM_rd_add_o), .MEM_regwrite_o(MEM_regwrite_o),
    .MEM_sel_to_reg_o(MEM_sel_to_reg_o), .MEM_alu_result_o(MEM_alu_result_o),
    .MEM_load_data_o(MEM_load_data_o), .MEM_pc_o(MEM_pc_o),
    .MEM_misalign_o(MEM_misalign_o)
  );

  // One instruction plus its memory timing and expected results.
  // g: cycle (from presentation) on which gnt is given;
  // r: extra cycles between the grant cycle + 1 and rvalid.
  typedef struct {
    logic [31:0] alu, rs2, pc, rdata;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  sel;
    logic        rd_mem, wr_mem;
    logic [2:0]  mem_op;
    int          g, r;
    int          exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
    logic        exp_mis, exp_rw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      op_bad = 1'b1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk_in(input logic [31:0] alu, input logic [31:0] rs2,
                                 input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                 input logic rdm, input logic wrm, input logic [2:0] op,
                                 input logic [31:0] pc, input int g, input int r,
                                 input logic [31:0] rdata);
    vec_t v;
    v.alu = alu; v.rs2 = rs2; v.rd = rd; v.regwrite = rw; v.sel = sel;
    v.rd_mem = rdm; v.wr_mem = wrm; v.mem_op = op; v.pc = pc;
    v.g = g; v.r = r; v.rdata = rdata;
    v.exp_stall = 0; v.exp_be = '0; v.exp_wdata = '0; v.exp_load = '0;
    v.exp_mis = 1'b0; v.exp_rw = 1'b0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t vi, input int stall, input logic [3:0] be,
                                    input logic [31:0] wdata, input logic [31:0] load,
                                    input logic mis, input logic rw);
    vec_t v = vi;
    v.exp_stall = stall; v.exp_be = be; v.exp_wdata = wdata;
    v.exp_load = load; v.exp_mis = mis; v.exp_rw = rw;
    return v;
  endfunction

  // Reference model: works per byte lane from access size and offset.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int size, off;
    bit ld, st, sgn;
    logic [31:0] mask, val;
    size = (v.mem_op == 3'd0 || v.mem_op == 3'd4) ? 1 :
           (v.mem_op == 3'd1 || v.mem_op == 3'd5) ? 2 : 4;
    sgn  = (v.mem_op == 3'd0 || v.mem_op == 3'd1);
    off  = int'(v.alu[1:0]);
    ld   = v.rd_mem;
    st   = v.wr_mem && !v.rd_mem;
    v.exp_mis = (ld || st) && ((off % size) != 0);
    v.exp_rw  = v.regwrite && !v.exp_mis;
    if (!(ld || st) || v.exp_mis) v.exp_stall = 0;
    else if (st)                  v.exp_stall = v.g;
    else                          v.exp_stall = v.g + 1 + v.r;
    for (int i = 0; i < 4; i++) begin
      v.exp_be[i] = ld || (i >= off && i < off + size);
      v.exp_wdata[8*i +: 8] = v.rs2[8*(i % size) +: 8];
    end
    val = v.rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      val  = val & mask;
      if (sgn && val[8*size-1]) val = val | ~mask;
    end
    v.exp_load = val;
    return v;
  endfunction

  task automatic drive_idle();
    EX_alu_result_i = '0; EX_rs2_data_i = '0; EX_pc_i = '0; EX_rd_add_i = '0;
    EX_regwrite_i = 1'b0; EX_sel_to_reg_i = '0; EX_RD_mem_i = 1'b0; EX_WR_mem_i = 1'b0;
    EX_mem_op_i = 3'b010; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic do_op(input vec_t v, input string tag);
    bit access, ld, exp_req;
    op_bad = 1'b0;
    ld     = v.rd_mem;
    access = (v.rd_mem || v.wr_mem) && !v.exp_mis;
    EX_alu_result_i = v.alu; EX_rs2_data_i = v.rs2; EX_pc_i = v.pc; EX_rd_add_i = v.rd;
    EX_regwrite_i = v.regwrite; EX_sel_to_reg_i = v.sel;
    EX_RD_mem_i = v.rd_mem; EX_WR_mem_i = v.wr_mem; EX_mem_op_i = v.mem_op;
    for (int cyc = 0; cyc <= v.exp_stall; cyc++) begin
      dmem_gnt_i    = access && (cyc == v.g);
      dmem_rvalid_i = access && ld && (cyc == v.g + 1 + v.r);
      dmem_rdata_i  = dmem_rvalid_i ? v.rdata : $urandom;
      exp_req       = access && (cyc <= v.g);
      @(negedge clk);
      chk({tag, ".stall"}, stall_o, cyc < v.exp_stall);
      chk({tag, ".req"}, dmem_req_o, exp_req);
      if (exp_req) begin
        chk({tag, ".addr"}, dmem_addr_o, {v.alu[31:2], 2'b00});
        chk({tag, ".be"}, dmem_be_o, v.exp_be);
        chk({tag, ".we"}, dmem_we_o, !ld);
        if (!ld) chk({tag, ".wdata"}, dmem_wdata_o, v.exp_wdata);
      end
      if (cyc == 0) chk({tag, ".fwd"}, MEM_fwd_data_o, v.alu);
      if (cyc > 0) begin
        chk({tag, ".bubble_rw"}, MEM_regwrite_o, 1'b0);
        chk({tag, ".bubble_mis"}, MEM_misalign_o, 1'b0);
      end
      @(posedge clk); #1;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk({tag, ".rd"}, MEM_rd_add_o, v.rd);
    chk({tag, ".rw"}, MEM_regwrite_o, v.exp_rw);
    chk({tag, ".sel"}, MEM_sel_to_reg_o, v.sel);
    chk({tag, ".alu"}, MEM_alu_result_o, v.alu);
    chk({tag, ".pc"}, MEM_pc_o, v.pc);
    chk({tag, ".mis"}, MEM_misalign_o, v.exp_mis);
    if (access && ld) chk({tag, ".load"}, MEM_load_data_o, v.exp_load);
    // resynchronise after a divergence so later ops are judged on their own
    if (op_bad) do_reset();
  endtask

  task automatic chk_mem_zero(input string tag);
    chk({tag, ".rd0"}, MEM_rd_add_o, 0);
    chk({tag, ".rw0"}, MEM_regwrite_o, 0);
    chk({tag, ".sel0"}, MEM_sel_to_reg_o, 0);
    chk({tag, ".alu0"}, MEM_alu_result_o, 0);
    chk({tag, ".load0"}, MEM_load_data_o, 0);
    chk({tag, ".pc0"}, MEM_pc_o, 0);
    chk({tag, ".mis0"}, MEM_misalign_o, 0);
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    //               alu         rs2           rd rw sel rdm wrm op      pc          g  r  rdata
    tbl[0]  = with_exp(mk_in(32'h0000_1234, 32'h0,        5, 1, 0, 0, 0, 3'b000, 32'h1000, 0, 0, 32'h0),
                       0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[1]  = with_exp(mk_in(32'h0000_0103, 32'h0,        6, 1, 1, 1, 0, 3'b000, 32'h1004, 0, 2, 32'h80AA_BBCC),
                       3, 4'hF, 32'h0, 32'hFFFF_FF80, 0, 1);
    tbl[2]  = with_exp(mk_in(32'h0000_0103, 32'h0,        6, 1, 1, 1, 0, 3'b100, 32'h1008, 0, 2, 32'h80AA_BBCC),
                       3, 4'hF, 32'h0, 32'h0000_0080, 0, 1);
    tbl[3]  = with_exp(mk_in(32'h0000_0022, 32'h1234_ABCD, 0, 0, 0, 0, 1, 3'b001, 32'h100C, 3, 0, 32'h0),
                       3, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0);
    tbl[4]  = with_exp(mk_in(32'h0000_0041, 32'h0,        8, 1, 1, 1, 0, 3'b010, 32'h1010, 0, 0, 32'h0),
                       0, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[5]  = with_exp(mk_in(32'h0000_CAFE, 32'h0,        9, 1, 0, 0, 0, 3'b000, 32'h1014, 0, 0, 32'h0),
                       0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[6]  = with_exp(mk_in(32'h0000_0010, 32'h0,       10, 1, 1, 1, 0, 3'b010, 32'h1018, 0, 0, 32'hDEAD_BEEF),
                       1, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1);
    tbl[7]  = with_exp(mk_in(32'h0000_0014, 32'h0,       11, 1, 1, 1, 0, 3'b010, 32'h101C, 0, 0, 32'h0123_4567),
                       1, 4'hF, 32'h0, 32'h0123_4567, 0, 1);
    tbl[8]  = with_exp(mk_in(32'h0000_0042, 32'h0,       12, 1, 1, 1, 0, 3'b001, 32'h1020, 1, 1, 32'h8001_7FFF),
                       3, 4'hF, 32'h0, 32'hFFFF_8001, 0, 1);
    tbl[9]  = with_exp(mk_in(32'h0000_0042, 32'h0,       12, 1, 1, 1, 0, 3'b101, 32'h1024, 1, 1, 32'h8001_7FFF),
                       3, 4'hF, 32'h0, 32'h0000_8001, 0, 1);
    tbl[10] = with_exp(mk_in(32'h0000_0001, 32'h0000_00AB, 0, 0, 0, 0, 1, 3'b000, 32'h1028, 0, 0, 32'h0),
                       0, 4'b0010, 32'hABAB_ABAB, 32'h0, 0, 0);
    tbl[11] = with_exp(mk_in(32'h0000_0008, 32'h1122_3344, 0, 0, 0, 0, 1, 3'b010, 32'h102C, 1, 0, 32'h0),
                       1, 4'hF, 32'h1122_3344, 32'h0, 0, 0);
    tbl[12] = with_exp(mk_in(32'h0000_0006, 32'h0,       13, 1, 1, 1, 0, 3'b011, 32'h1030, 0, 0, 32'h0),
                       0, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[13] = with_exp(mk_in(32'h0000_0020, 32'hFFFF_FFFF, 14, 1, 1, 1, 1, 3'b010, 32'h1034, 0, 1, 32'h5A5A_0000),
                       2, 4'hF, 32'h0, 32'h5A5A_0000, 0, 1);
    tbl[14] = with_exp(mk_in(32'h0000_0023, 32'h0,       15, 1, 1, 1, 0, 3'b001, 32'h1038, 0, 0, 32'h0),
                       0, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[15] = with_exp(mk_in(32'h0000_0004, 32'h9988_7766, 0, 0, 0, 0, 1, 3'b111, 32'h103C, 0, 0, 32'h0),
                       0, 4'hF, 32'h9988_7766, 32'h0, 0, 0);

    // reset with an aligned load presented: no request, no stall
    rst = 1'b1;
    drive_idle();
    EX_alu_result_i = 32'h40; EX_RD_mem_i = 1'b1; EX_regwrite_i = 1'b1; EX_rd_add_i = 5'd3;
    @(negedge clk);
    chk("rst.stall", stall_o, 1'b0);
    chk("rst.req", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    chk_mem_zero("rst");
    rst = 1'b0;
    drive_idle();

    for (int i = 0; i < 16; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

    // reset while waiting for read data; the late rvalid must be ignored
    op_bad = 1'b0;
    EX_alu_result_i = 32'h30; EX_RD_mem_i = 1'b1; EX_WR_mem_i = 1'b0; EX_mem_op_i = 3'b010;
    EX_regwrite_i = 1'b1; EX_rd_add_i = 5'd7; EX_pc_i = 32'h2000; dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rstmid.stall_req", stall_o, 1'b1);
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.stall_in_rst", stall_o, 1'b0);
    chk("rstmid.req_in_rst", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_mem_zero("rstmid");
    drive_idle();
    EX_alu_result_i = 32'h5555; EX_rd_add_i = 5'd9; EX_regwrite_i = 1'b1; EX_pc_i = 32'h2004;
    @(negedge clk);
    chk("rstmid.idle_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    chk("rstmid.alu1", MEM_alu_result_o, 32'h5555);
    EX_alu_result_i = 32'h6666; EX_rd_add_i = 5'd10; EX_pc_i = 32'h2008;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rstmid.late_rvalid_stall", stall_o, 1'b0);
    chk("rstmid.late_rvalid_req", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    chk("rstmid.alu2", MEM_alu_result_o, 32'h6666);
    chk("rstmid.rd2", MEM_rd_add_o, 5'd10);
    chk("rstmid.rw2", MEM_regwrite_o, 1'b1);
    if (op_bad) do_reset();

    // randomized instruction stream against the reference model
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      rv = mk_in($urandom, $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
                 kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 1) rv.alu[1:0] = 2'b00;
      rv = model(rv);
      do_op(rv, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
